// File: rtl/dunit_pkg.sv
// dunit_pkg: command, reply and status codes plus FSM states for the debug unit controller
package dunit_pkg;
  localparam logic [7:0] CMD_LOAD = 8'h4C, CMD_RST = 8'h52, CMD_RUN = 8'h43, CMD_STEP = 8'h53;
  localparam logic [7:0] RSP_ACK = 8'h4B, RSP_ERR = 8'hEE;
  localparam logic [7:0] ST_HALT = 8'hA0, ST_STEP = 8'hA1, ST_TIMEOUT = 8'hAF;
  typedef enum logic [3:0] {
    IDLE, LD_CNT, LD_BYTE, LD_WR, PC_RST, RUN, STEP, D_ADDR, D_WAIT, D_TX, SEND1
  } state_t;
endpackage

// File: rtl/dunit_word_tx.sv
// dunit_word_tx: sends a latched word (or only its low byte) MSB first over valid/ready, pulses done
module dunit_word_tx #(
  parameter int NB_REG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              single,
  input  logic [NB_REG-1:0] word,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              done
);
  logic [NB_REG-1:0] sh;
  logic [1:0] left;
  assign tx_data = sh[NB_REG-1 -: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh <= '0;
      left <= '0;
      tx_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !tx_valid) begin
        sh <= single ? {word[7:0], {(NB_REG-8){1'b0}}} : word;
        left <= single ? 2'd0 : 2'd3;
        tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        sh <= sh << 8;
        left <= left - 2'd1;
        tx_valid <= left != 2'd0;
        done <= left == 2'd0;
      end
    end
endmodule

// File: rtl/debug_unit_ctrl.sv
// debug_unit_ctrl: UART-driven debug master; loads imem, resets PC, runs/steps the pipeline and
// dumps the register file and data memory back over the transmitter
module debug_unit_ctrl import dunit_pkg::*; #(
  parameter int NB_REG      = 32,
  parameter int IMEM_WORDS  = 128,
  parameter int MEM_WORDS   = 32,
  parameter int N_REGS      = 32,
  parameter int RD_LAT      = 1,
  parameter int RUN_TIMEOUT = 2**20
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_tx_ready,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_halt,
  input  logic [NB_REG-1:0] i_dunit_reg,
  input  logic [NB_REG-1:0] i_dunit_mem_data,
  output logic              o_dunit_clk_en,
  output logic              o_dunit_reset_pc,
  output logic              o_dunit_w_mem,
  output logic [NB_REG-1:0] o_dunit_addr,
  output logic [NB_REG-1:0] o_dunit_data,
  output logic              o_busy
);
  localparam int DW = $clog2(N_REGS + MEM_WORDS) + 1;
  state_t state;
  logic [7:0] n_words, word_idx, wait_cnt;
  logic [1:0] byte_idx;
  logic [DW-1:0] dump_idx;
  logic [20:0] run_cnt;
  logic run_q, dump_q, tx_start, tx_single, tx_done, last;
  logic [NB_REG-1:0] tx_word;
  // Registers are addressed by index, data memory by byte address
  function automatic logic [NB_REG-1:0] addr_of(input logic [DW-1:0] i);
    return i < DW'(N_REGS) ? NB_REG'(i) : NB_REG'({i - DW'(N_REGS), 2'b00});
  endfunction
  assign o_dunit_clk_en = run_q & ~i_halt;
  assign o_busy = state != IDLE;
  assign last = dump_idx == DW'(N_REGS + MEM_WORDS - 1);
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      n_words <= '0;
      word_idx <= '0;
      wait_cnt <= '0;
      byte_idx <= '0;
      dump_idx <= '0;
      run_cnt <= '0;
      run_q <= 1'b0;
      dump_q <= 1'b0;
      tx_start <= 1'b0;
      tx_single <= 1'b0;
      tx_word <= '0;
      o_dunit_reset_pc <= 1'b0;
      o_dunit_w_mem <= 1'b0;
      o_dunit_addr <= '0;
      o_dunit_data <= '0;
    end else begin
      tx_start <= 1'b0;
      o_dunit_w_mem <= 1'b0;
      o_dunit_reset_pc <= 1'b0;
      case (state)
        IDLE: if (i_rx_valid) begin
          tx_single <= 1'b1;
          tx_word <= NB_REG'(RSP_ERR);
          dump_q <= 1'b0;
          case (i_rx_data)
            CMD_LOAD: state <= LD_CNT;
            CMD_RST: begin o_dunit_reset_pc <= 1'b1; state <= PC_RST; end
            CMD_RUN: begin run_q <= 1'b1; run_cnt <= '0; state <= RUN; end
            CMD_STEP: begin run_q <= 1'b1; state <= STEP; end
            default: begin tx_start <= 1'b1; state <= SEND1; end
          endcase
        end
        LD_CNT: if (i_rx_valid) begin
          n_words <= i_rx_data;
          word_idx <= '0;
          byte_idx <= '0;
          if (32'(i_rx_data) > IMEM_WORDS) begin
            tx_word <= NB_REG'(RSP_ERR);
            tx_start <= 1'b1;
            state <= SEND1;
          end else if (i_rx_data == 8'd0) begin
            o_dunit_reset_pc <= 1'b1;
            state <= PC_RST;
          end else state <= LD_BYTE;
        end
        LD_BYTE: if (i_rx_valid) begin
          o_dunit_data <= {o_dunit_data[NB_REG-9:0], i_rx_data};
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            o_dunit_addr <= NB_REG'({word_idx, 2'b00});
            o_dunit_w_mem <= 1'b1;
            state <= LD_WR;
          end
        end
        LD_WR: begin
          word_idx <= word_idx + 8'd1;
          byte_idx <= '0;
          o_dunit_reset_pc <= word_idx == n_words - 8'd1;
          state <= word_idx == n_words - 8'd1 ? PC_RST : LD_BYTE;
        end
        PC_RST: begin
          tx_word <= NB_REG'(RSP_ACK);
          tx_single <= 1'b1;
          tx_start <= 1'b1;
          dump_q <= 1'b0;
          state <= SEND1;
        end
        // Halt is checked first so it wins over a coincident timeout
        RUN: if (i_halt || run_cnt == 21'(RUN_TIMEOUT - 1)) begin
          run_q <= 1'b0;
          tx_word <= NB_REG'(i_halt ? ST_HALT : ST_TIMEOUT);
          tx_single <= 1'b1;
          tx_start <= 1'b1;
          dump_q <= 1'b1;
          state <= SEND1;
        end else run_cnt <= run_cnt + 21'd1;
        STEP: begin
          run_q <= 1'b0;
          tx_word <= NB_REG'(i_halt ? ST_HALT : ST_STEP);
          tx_single <= 1'b1;
          tx_start <= 1'b1;
          dump_q <= 1'b1;
          state <= SEND1;
        end
        SEND1: if (tx_done) begin
          dump_idx <= '0;
          if (dump_q) o_dunit_addr <= '0;
          state <= dump_q ? D_ADDR : IDLE;
        end
        D_ADDR: begin
          wait_cnt <= 8'd1;
          state <= D_WAIT;
        end
        D_WAIT: if (wait_cnt >= 8'(RD_LAT)) begin
          tx_word <= dump_idx < DW'(N_REGS) ? i_dunit_reg : i_dunit_mem_data;
          tx_single <= 1'b0;
          tx_start <= 1'b1;
          state <= D_TX;
        end else wait_cnt <= wait_cnt + 8'd1;
        D_TX: if (tx_done) begin
          dump_idx <= dump_idx + DW'(1);
          o_dunit_addr <= addr_of(dump_idx + DW'(1));
          dump_q <= ~last;
          state <= last ? IDLE : D_ADDR;
        end
        default: state <= IDLE;
      endcase
    end
  dunit_word_tx #(.NB_REG(NB_REG)) u_tx (
    .clk(i_clk),
    .rst(i_reset),
    .start(tx_start),
    .single(tx_single),
    .word(tx_word),
    .tx_ready(i_tx_ready),
    .tx_data(o_tx_data),
    .tx_valid(o_tx_valid),
    .done(tx_done)
  );
endmodule
